// File: rtl/instr_issue_if.sv
// Loader and controller-FSM facing signals of the instruction issue stage.
// slave is the issue stage's view; master is the view of whatever drives it.
interface instr_issue_if;
  logic [15:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic        w;
  logic [2:0]  nsel;
  logic        s;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [1:0]  shift;
  logic [2:0]  regnum;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        busy;
  logic        halted;

  modport slave (
    input  in_instr, in_valid, w, nsel,
    output in_ready, s, opcode, op, shift, regnum, sximm8, sximm5, busy, halted
  );

  modport master (
    output in_instr, in_valid, w, nsel,
    input  in_ready, s, opcode, op, shift, regnum, sximm8, sximm5, busy, halted
  );
endinterface

// File: rtl/instr_issue.sv
// Instruction FIFO plus current-instruction register feeding the controller FSM.
// Issues one instruction per FSM WAIT, holds s until the FSM leaves WAIT, stops on HALT.
module instr_issue #(
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  instr_issue_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] ACK   = 3'd2;
  localparam logic [2:0] EXEC  = 3'd3;
  localparam logic [2:0] HALT  = 3'd4;

  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q, in_ready_d;
  logic [15:0]   cir_q, cir_d;
  logic [2:0]    state_q, state_d;

  logic        push;
  logic        pop;
  logic [15:0] head;

  assign head = mem_q[rd_ptr_q];
  assign push = bus.in_valid && in_ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0) && bus.w;

  // in_ready is the registered "not full" of the post-edge count, so a full
  // FIFO never accepts a word in the same cycle it pops one.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_instr;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CW'(DEPTH));
  end

  always_comb begin
    state_d = state_q;
    cir_d   = cir_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          cir_d   = head;
          state_d = (head[15:13] == 3'b111) ? HALT : START;
        end
      end
      START:   state_d = ACK;
      ACK:     if (!bus.w) state_d = EXEC;
      EXEC:    if (bus.w) state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      cir_q      <= '0;
      state_q    <= IDLE;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      cir_q      <= cir_d;
      state_q    <= state_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.s        = (state_q == START) || (state_q == ACK);
  assign bus.busy     = (state_q != IDLE);
  assign bus.halted   = (state_q == HALT);
  assign bus.opcode   = cir_q[15:13];
  assign bus.op       = cir_q[12:11];
  assign bus.shift    = cir_q[4:3];
  assign bus.sximm8   = {{8{cir_q[7]}}, cir_q[7:0]};
  assign bus.sximm5   = {{11{cir_q[4]}}, cir_q[4:0]};

  always_comb begin
    case (bus.nsel)
      3'b100:  bus.regnum = cir_q[10:8];
      3'b010:  bus.regnum = cir_q[7:5];
      3'b001:  bus.regnum = cir_q[2:0];
      default: bus.regnum = 3'b000;
    endcase
  end
endmodule

// File: tb/tb_instr_issue.sv
// Scoreboard bench for instr_issue: stimulus queues hand-decoded expectations,
// a monitor checks every issued instruction while the FSM runs it.
module tb_instr_issue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_issue_if bif ();
  instr_issue #(.DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bif));

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  shift;
    logic [2:0]  rn, rd, rm;
    logic [15:0] sx8, sx5;
  } rec_t;

  rec_t vec [5];
  rec_t sb [$];
  rec_t cur;
  bit   have = 0;
  bit   s_prev = 0;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [2:0] exp_reg(input rec_t r, input logic [2:0] ns);
    case (ns)
      3'b100:  return r.rn;
      3'b010:  return r.rd;
      3'b001:  return r.rm;
      default: return 3'b000;
    endcase
  endfunction

  // Monitor: a rising s means a new issue; fields must hold for the whole run.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        if (bif.s && !s_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_issue", 32'd1, 32'd0);
            have = 0;
          end else begin
            cur  = sb.pop_front();
            have = 1;
          end
        end
        if (bif.busy && !bif.halted && have) begin
          chk("opcode", bif.opcode, cur.opcode);
          chk("op", bif.op, cur.op);
          chk("shift", bif.shift, cur.shift);
          chk("sximm8", bif.sximm8, cur.sx8);
          chk("sximm5", bif.sximm5, cur.sx5);
          chk("regnum", bif.regnum, exp_reg(cur, bif.nsel));
        end
        s_prev = bif.s;
      end else begin
        s_prev = 0;
        have   = 0;
      end
    end
  end

  task automatic push_word(input int idx, input bit issues);
    bit acc = 0;
    if (issues) sb.push_back(vec[idx]);
    bif.in_instr = vec[idx].instr;
    bif.in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = bif.in_ready;
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_s();
    int n = 0;
    while (!bif.s && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_seen", bif.s, 1'b1);
  endtask

  // Plays the controller FSM: leave WAIT after hold cycles, exercise nsel, return to WAIT.
  task automatic run_one(input int hold);
    wait_s();
    for (int i = 0; i < hold; i++) begin
      chk("s_held", bif.s, 1'b1);
      @(negedge clk);
    end
    bif.w = 1'b0;
    @(negedge clk);
    chk("s_drop", bif.s, 1'b0);
    chk("busy_exec", bif.busy, 1'b1);
    bif.nsel = 3'b010;
    @(negedge clk);
    bif.nsel = 3'b001;
    @(negedge clk);
    bif.nsel = 3'b011;
    @(negedge clk);
    chk("busy_still", bif.busy, 1'b1);
    bif.nsel = 3'b100;
    bif.w    = 1'b1;
    @(negedge clk);
    chk("busy_done", bif.busy, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s"}, bif.s, 1'b0);
    chk({tag, "_busy"}, bif.busy, 1'b0);
    chk({tag, "_halted"}, bif.halted, 1'b0);
    chk({tag, "_in_ready"}, bif.in_ready, 1'b1);
    chk({tag, "_fields"}, {bif.opcode, bif.op, bif.shift, bif.regnum}, 32'd0);
    chk({tag, "_sximm"}, {bif.sximm8, bif.sximm5}, 32'd0);
  endtask

  initial begin
    vec[0] = '{16'hD105, 3'b110, 2'b10, 2'b00, 3'd1, 3'd0, 3'd5, 16'h0005, 16'h0005};
    vec[1] = '{16'hD2FF, 3'b110, 2'b10, 2'b11, 3'd2, 3'd7, 3'd7, 16'hFFFF, 16'hFFFF};
    vec[2] = '{16'hA070, 3'b101, 2'b00, 2'b10, 3'd0, 3'd3, 3'd0, 16'h0070, 16'hFFF0};
    vec[3] = '{16'h4B2C, 3'b010, 2'b01, 2'b01, 3'd3, 3'd1, 3'd4, 16'h002C, 16'h000C};
    vec[4] = '{16'hE000, 3'b111, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000};

    reset        = 1'b0;
    bif.in_instr = '0;
    bif.in_valid = 1'b0;
    bif.w        = 1'b1;
    bif.nsel     = 3'b100;
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);

    push_word(0, 1);
    run_one(1);

    push_word(1, 1);
    push_word(2, 1);
    run_one(1);
    run_one(2);

    bif.w = 1'b0;
    @(negedge clk);
    push_word(2, 1);
    push_word(1, 1);
    chk("full_after_two", bif.in_ready, 1'b0);
    chk("no_issue_w0", bif.busy, 1'b0);
    fork
      push_word(3, 1);
      begin
        repeat (3) @(negedge clk);
        chk("still_full", bif.in_ready, 1'b0);
        bif.w = 1'b1;
      end
    join
    run_one(3);
    run_one(1);
    run_one(1);
    chk("sb_drained", sb.size(), 32'd0);

    push_word(4, 0);
    push_word(0, 0);
    repeat (3) @(negedge clk);
    chk("halted", bif.halted, 1'b1);
    chk("halt_no_s", bif.s, 1'b0);
    chk("halt_busy", bif.busy, 1'b1);
    chk("halt_accepts", bif.in_ready, 1'b1);
    push_word(3, 0);
    chk("halt_full", bif.in_ready, 1'b0);
    repeat (4) @(negedge clk);
    chk("halt_stays", bif.halted, 1'b1);
    chk("halt_no_s2", bif.s, 1'b0);
    reset = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("halt_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    push_word(0, 1);
    wait_s();
    @(negedge clk);
    bif.w = 1'b0;
    @(negedge clk);
    chk("exec_s", bif.s, 1'b0);
    chk("exec_busy", bif.busy, 1'b1);
    push_word(1, 0);
    push_word(2, 0);
    chk("exec_full", bif.in_ready, 1'b0);
    chk("exec_busy2", bif.busy, 1'b1);
    #1 reset = 1'b0;
    sb.delete();
    #1;
    chk_reset_outputs("exec_rst");
    @(negedge clk);
    reset = 1'b1;
    bif.w = 1'b1;
    @(negedge clk);

    push_word(3, 1);
    run_one(1);
    chk("sb_final", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
